pc_fetch_sequencer: RTL and testbench
=====================================

# pc_fetch_sequencer

Program-counter and fetch-sequencing stage that sits directly upstream of the instruction memory in the single-cycle MIPS datapath. It produces the byte address the instruction memory reads. It generates the memory's load strobe on program start and computes the next PC from sequential, branch, jump and jump-register sources. It also stops the machine cleanly when the program runs off its end.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset and on every program start
- END_PC, 32'd84, first byte address past the last instruction; PC ≥ END_PC means the program is finished
- LOAD_CYCLES, 2, cycles `imem_start` is held high before fetching begins (≥1)

- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  level; sampled in IDLE/HALT to begin a program run
- stall  in  1  hold PC and retire nothing this cycle (RUN only)
- instruction  in  32  instruction word returned combinationally by instruction memory for `pc`
- branch_taken  in  1  branch condition true for current instruction (Branch & Zero)
- jump  in  1  current instruction is j/jal
- jump_reg  in  1  current instruction is jr
- reg_target  in  32  rs value for jr
- pc  out  32  fetch address to instruction memory
- pc_plus4  out  32  pc + 4, combinational, for link/branch use
- imem_start  out  1  load strobe to instruction memory (its start input)
- instr_valid  out  1  high in RUN when not stalled; current instruction retires this edge
- halted  out  1  high in HALT
- fault  out  1  high in HALT if halt was entered with pc ≠ END_PC or misaligned target
- retired  out  32  count of retired instructions since last start

## Operation
- States: IDLE → LOAD → RUN → HALT; HALT → LOAD on `start`.
- IDLE: pc = RESET_PC; waits for `start`=1.
- LOAD: `imem_start`=1 for LOAD_CYCLES cycles (internal down-counter), pc = RESET_PC, `retired` cleared on entry; then RUN.
- RUN, next-PC priority: jump_reg → reg_target; else jump → {pc_plus4[31:28], instruction[25:0], 2'b00}; else branch_taken → pc_plus4 + {sext(instruction[15:0]), 2'b00}; else pc_plus4.
- All arithmetic 32-bit modulo 2^32; wrap is not detected except via END_PC rule.
- jr with reg_target[1:0] ≠ 0: target bits [1:0] forced to 00, fault latched.
- stall=1 in RUN: pc, retired unchanged, instr_valid=0, control inputs ignored.
- Halt check on registered pc: in RUN, if pc ≥ END_PC (unsigned) → HALT next edge, no retire that cycle; fault=1 if pc ≠ END_PC.
- `start` ignored in LOAD and RUN. In HALT, `start` clears fault and re-enters LOAD.

## Timing
- Reset values: pc=RESET_PC, imem_start=0, instr_valid=0, halted=0, fault=0, retired=0, state=IDLE.
- rst asserted at any edge (including mid-LOAD or mid-RUN) forces reset values on that edge; rst dominates start.
- start sampled at edge N in IDLE → imem_start=1 cycles N+1..N+LOAD_CYCLES → RUN from N+LOAD_CYCLES+1 with pc=RESET_PC.
- pc registered; instruction memory combinational, so instruction for pc valid same cycle; one instruction per non-stalled RUN cycle; next-PC latency 1 cycle.
- instr_valid, pc_plus4 combinational from state/pc/stall; halted, fault, imem_start registered.
- retired increments on edges where instr_valid=1; saturates at 32'hFFFF_FFFF.

## Structure
- Shared package `fetch_pkg`: state encoding (IDLE=2'd0, LOAD=2'd1, RUN=2'd2, HALT=2'd3), PC_STEP=32'd4, jump/branch field position constants.
- One sub-module: `next_pc_mux` (combinational priority select + branch/jump target arithmetic + alignment check); FSM, counters and registers stay in top.

## Test plan
- rst, start=1 one cycle, LOAD_CYCLES=2 -> imem_start high exactly 2 cycles; RUN then pc 0,4,8,…,80,84; halted=1 at edge after pc=84; retired=21; fault=0.
- RUN at pc=8, instruction imm=16'hFFFE, branch_taken=1 -> next pc=8+4-8=4.
- pc=12, jump=1, instruction[25:0]=26'd10 -> next pc=40; same cycle jump_reg=1, reg_target=32'h20 -> next pc=32 (jr wins).
- stall=1 for 3 cycles at pc=16 -> pc stays 16, instr_valid=0, retired unchanged; resumes at 20.
- jump_reg=1, reg_target=32'h66 -> pc=32'h64; then pc≥84 path: reg_target=32'h100 -> HALT with fault=1; start -> fault=0, LOAD, pc=0.
- rst asserted mid-RUN at pc=40 with start=1 -> next edge pc=0, state IDLE, retired=0, imem_start=0.

Source files
------------

// File: rtl/pc_fetch_sequencer_pkg.sv
// Shared definitions for the fetch stage: FSM states, PC step and
// instruction field positions used by the next-PC arithmetic.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        HALT = 2'd3
    } state_t;

    localparam logic [31:0] PC_STEP   = 32'd4;
    localparam int unsigned J_IDX_MSB = 25;   // j/jal instr_index is [25:0]
    localparam int unsigned J_SEG_LSB = 28;   // jump keeps the 256 MB segment of pc+4
    localparam int unsigned B_IMM_MSB = 15;   // branch offset is [15:0]

    // Word offset of a branch: sign-extend and scale to bytes.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/pc_fetch_sequencer_if.sv
// Fetch-stage bus: control inputs from the datapath/host, fetch address
// and status outputs towards instruction memory and the rest of the core.
interface pc_fetch_sequencer_if;

    logic        start;
    logic        stall;
    logic [31:0] instruction;
    logic        branch_taken;
    logic        jump;
    logic        jump_reg;
    logic [31:0] reg_target;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        imem_start;
    logic        instr_valid;
    logic        halted;
    logic        fault;
    logic [31:0] retired;

    modport master (
        input  start, stall, instruction, branch_taken, jump, jump_reg, reg_target,
        output pc, pc_plus4, imem_start, instr_valid, halted, fault, retired
    );

    modport slave (
        output start, stall, instruction, branch_taken, jump, jump_reg, reg_target,
        input  pc, pc_plus4, imem_start, instr_valid, halted, fault, retired
    );

endinterface

// File: rtl/pc_fetch_sequencer_next_pc_mux.sv
// Next-PC selection: jr > j/jal > taken branch > sequential, with the
// jr target forced word-aligned and the misalignment reported.
module next_pc_mux
    import fetch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] instruction,
    input  logic        branch_taken,
    input  logic        jump,
    input  logic        jump_reg,
    input  logic [31:0] reg_target,
    output logic [31:0] pc_plus4,
    output logic [31:0] next_pc,
    output logic        misaligned
);

    logic [31:0] jump_target;
    logic [31:0] branch_target;
    logic        unused_opcode;

    // Opcode bits are decoded elsewhere; only the address fields matter here.
    assign unused_opcode = ^instruction[31:J_IDX_MSB+1];

    always_comb begin
        pc_plus4      = pc + PC_STEP;
        jump_target   = {pc_plus4[31:J_SEG_LSB], instruction[J_IDX_MSB:0], 2'b00};
        branch_target = pc_plus4 + branch_offset(instruction[B_IMM_MSB:0]);
        next_pc       = pc_plus4;
        misaligned    = 1'b0;
        if (jump_reg) begin
            next_pc    = {reg_target[31:2], 2'b00};
            misaligned = (reg_target[1:0] != 2'b00);
        end else if (jump) begin
            next_pc = jump_target;
        end else if (branch_taken) begin
            next_pc = branch_target;
        end
    end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Program counter and fetch sequencer: IDLE -> LOAD (imem load strobe) ->
// RUN (one instruction per unstalled cycle) -> HALT when pc leaves the program.
module pc_fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] END_PC      = 32'd84,
    parameter int unsigned LOAD_CYCLES = 2
) (
    input logic                  clk,
    input logic                  rst,
    pc_fetch_sequencer_if.master bus
);

    localparam int unsigned      CNT_W    = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LOAD_CYCLES - 1);

    state_t           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      retired_q, retired_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mis_q, mis_d;
    logic             fault_q, fault_d;
    logic             halted_q, imem_q;
    logic [31:0]      next_pc, pc_plus4;
    logic             misaligned;
    logic             at_end;
    logic             retire;

    next_pc_mux u_next_pc_mux (
        .pc           (pc_q),
        .instruction  (bus.instruction),
        .branch_taken (bus.branch_taken),
        .jump         (bus.jump),
        .jump_reg     (bus.jump_reg),
        .reg_target   (bus.reg_target),
        .pc_plus4     (pc_plus4),
        .next_pc      (next_pc),
        .misaligned   (misaligned)
    );

    assign at_end = (pc_q >= END_PC);
    assign retire = (state_q == RUN) && !bus.stall && !at_end;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        retired_d = retired_q;
        cnt_d     = cnt_q;
        mis_d     = mis_q;
        fault_d   = fault_q;
        case (state_q)
            IDLE, HALT: begin
                if (bus.start) begin
                    state_d   = LOAD;
                    cnt_d     = CNT_INIT;
                    pc_d      = RESET_PC;
                    retired_d = '0;
                    mis_d     = 1'b0;
                    fault_d   = 1'b0;
                end
            end
            LOAD: begin
                if (cnt_q == '0) state_d = RUN;
                else             cnt_d   = cnt_q - 1'b1;
            end
            RUN: begin
                // The end check runs even when stalled so a finished program always halts.
                if (at_end) begin
                    state_d = HALT;
                    fault_d = (pc_q != END_PC) || mis_q;
                end else if (retire) begin
                    pc_d      = next_pc;
                    mis_d     = mis_q | misaligned;
                    retired_d = (retired_q == '1) ? retired_q : retired_q + 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            retired_q <= '0;
            cnt_q     <= '0;
            mis_q     <= 1'b0;
            fault_q   <= 1'b0;
            halted_q  <= 1'b0;
            imem_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            retired_q <= retired_d;
            cnt_q     <= cnt_d;
            mis_q     <= mis_d;
            fault_q   <= fault_d;
            halted_q  <= (state_d == HALT);
            imem_q    <= (state_d == LOAD);
        end
    end

    assign bus.pc          = pc_q;
    assign bus.pc_plus4    = pc_plus4;
    assign bus.imem_start  = imem_q;
    assign bus.instr_valid = retire;
    assign bus.halted      = halted_q;
    assign bus.fault       = fault_q;
    assign bus.retired     = retired_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Self-checking bench for pc_fetch_sequencer: directed scenarios followed by
// randomized control traffic, all compared against a cycle-level reference model.
module tb_pc_fetch_sequencer;

    localparam logic [31:0] END_PC = 32'd84;
    localparam int          LOADC  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pc_fetch_sequencer_if bus ();

    pc_fetch_sequencer #(
        .RESET_PC    (32'h0000_0000),
        .END_PC      (END_PC),
        .LOAD_CYCLES (LOADC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef enum {M_IDLE, M_LOAD, M_RUN, M_HALT} mphase_t;
    mphase_t     m_ph;
    int          m_left;
    logic [31:0] m_pc;
    logic [31:0] m_ret;
    bit          m_fault;
    bit          m_mis;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit s, input bit st, input logic [31:0] ins,
                         input bit br, input bit j, input bit jr, input logic [31:0] t);
        bus.start        = s;
        bus.stall        = st;
        bus.instruction  = ins;
        bus.branch_taken = br;
        bus.jump         = j;
        bus.jump_reg     = jr;
        bus.reg_target   = t;
    endtask

    task automatic nop();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    function automatic logic [31:0] model_target();
        logic [31:0] p4;
        int          off;
        p4 = m_pc + 32'd4;
        if (bus.jump_reg) begin
            if ((bus.reg_target & 32'd3) != 0) m_mis = 1'b1;
            return bus.reg_target & ~32'd3;
        end
        if (bus.jump)
            return (p4 & 32'hF000_0000) | ((bus.instruction & 32'h03FF_FFFF) << 2);
        if (bus.branch_taken) begin
            off = int'($signed(bus.instruction[15:0]));
            return p4 + 32'(off * 4);
        end
        return p4;
    endfunction

    task automatic compare();
        chk("pc",          bus.pc,               m_pc);
        chk("pc_plus4",    bus.pc_plus4,         m_pc + 32'd4);
        chk("imem_start",  32'(bus.imem_start),  32'(m_ph == M_LOAD));
        chk("instr_valid", 32'(bus.instr_valid),
            32'(m_ph == M_RUN && !bus.stall && m_pc < END_PC));
        chk("halted",      32'(bus.halted),      32'(m_ph == M_HALT));
        chk("fault",       32'(bus.fault),       32'(m_ph == M_HALT && m_fault));
        chk("retired",     bus.retired,          m_ret);
    endtask

    task automatic advance();
        if (rst) begin
            m_ph = M_IDLE; m_pc = 32'h0; m_ret = 32'h0;
            m_fault = 1'b0; m_mis = 1'b0; m_left = 0;
            return;
        end
        case (m_ph)
            M_IDLE, M_HALT: if (bus.start) begin
                m_ph = M_LOAD; m_left = LOADC; m_pc = 32'h0; m_ret = 32'h0;
                m_fault = 1'b0; m_mis = 1'b0;
            end
            M_LOAD: begin
                m_left--;
                if (m_left == 0) m_ph = M_RUN;
            end
            M_RUN: begin
                if (m_pc >= END_PC) begin
                    m_ph    = M_HALT;
                    m_fault = (m_pc != END_PC) || m_mis;
                end else if (!bus.stall) begin
                    m_pc = model_target();
                    if (m_ret != 32'hFFFF_FFFF) m_ret++;
                end
            end
        endcase
    endtask

    task automatic tick(input bit do_check);
        #1;
        if (do_check) compare();
        advance();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] ret_snap;
        logic [31:0] r;
        int          imm;

        nop();
        rst = 1'b1;
        @(negedge clk);
        tick(1'b0);
        tick(1'b1);
        rst = 1'b0;

        // Straight-line program: 21 instructions then halt at END_PC.
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0); tick(1'b1);
        nop();
        for (int i = 0; i < 30; i++) tick(1'b1);
        chk("seq_halted",  32'(bus.halted), 32'd1);
        chk("seq_retired", bus.retired,     32'd21);
        chk("seq_fault",   32'(bus.fault),  32'd0);
        chk("seq_pc",      bus.pc,          32'd84);

        // Restart from HALT, then branch/jump/jr priority cases.
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0); tick(1'b1);
        nop();
        for (int i = 0; i < 4; i++) tick(1'b1);
        chk("at_pc8", bus.pc, 32'd8);
        drive(1'b0, 1'b0, 32'h0000_FFFE, 1'b1, 1'b0, 1'b0, 32'h0); tick(1'b1);
        chk("branch_back", bus.pc, 32'd4);
        nop(); tick(1'b1); tick(1'b1);
        drive(1'b0, 1'b0, 32'd10, 1'b0, 1'b1, 1'b0, 32'h0); tick(1'b1);
        chk("jump", bus.pc, 32'd40);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'd12); tick(1'b1);
        drive(1'b0, 1'b0, 32'd10, 1'b0, 1'b1, 1'b1, 32'h20); tick(1'b1);
        chk("jr_wins", bus.pc, 32'd32);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'd16); tick(1'b1);
        ret_snap = m_ret;
        drive(1'b0, 1'b1, 32'd10, 1'b1, 1'b1, 1'b1, 32'h40);
        for (int i = 0; i < 3; i++) tick(1'b1);
        chk("stall_pc",  bus.pc,      32'd16);
        chk("stall_ret", bus.retired, ret_snap);
        nop(); tick(1'b1);
        chk("resume_pc", bus.pc, 32'd20);

        // Misaligned jr lands past the end: fault halt, then restart clears it.
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h66); tick(1'b1);
        chk("jr_align", bus.pc, 32'h64);
        nop(); tick(1'b1);
        chk("mis_halt",  32'(bus.halted), 32'd1);
        chk("mis_fault", 32'(bus.fault),  32'd1);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0); tick(1'b1);
        chk("restart_fault", 32'(bus.fault),      32'd0);
        chk("restart_load",  32'(bus.imem_start), 32'd1);
        chk("restart_pc",    bus.pc,              32'd0);
        nop(); tick(1'b1); tick(1'b1);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h100); tick(1'b1);
        nop(); tick(1'b1);
        chk("over_fault", 32'(bus.fault), 32'd1);

        // Reset mid-RUN at pc=40 with start held, then mid-LOAD.
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0); tick(1'b1);
        nop();
        for (int i = 0; i < 12; i++) tick(1'b1);
        chk("pre_rst_pc", bus.pc, 32'd40);
        rst = 1'b1; bus.start = 1'b1; tick(1'b1);
        chk("rst_pc",   bus.pc,              32'd0);
        chk("rst_ret",  bus.retired,         32'd0);
        chk("rst_imem", 32'(bus.imem_start), 32'd0);
        rst = 1'b0; bus.start = 1'b0; tick(1'b1);
        bus.start = 1'b1; tick(1'b1);
        bus.start = 1'b0; tick(1'b1);
        rst = 1'b1; tick(1'b1);
        chk("rst_load_imem", 32'(bus.imem_start), 32'd0);
        rst = 1'b0; tick(1'b1);

        // Randomized control traffic.
        for (int i = 0; i < 600; i++) begin
            r   = $urandom;
            imm = int'($urandom_range(0, 12)) - 6;
            drive($urandom_range(0, 9) == 0,
                  $urandom_range(0, 3) == 0,
                  {r[31:16], 16'(imm)},
                  $urandom_range(0, 4) == 0,
                  $urandom_range(0, 19) == 0,
                  $urandom_range(0, 19) == 0,
                  32'($urandom_range(0, 100)));
            rst = ($urandom_range(0, 99) == 0);
            tick(1'b1);
        end
        rst = 1'b0;
        nop();
        tick(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
